// File: rtl/oscilo_pkg.sv
// Shared oscilloscope definitions: sample-memory geometry and the dump FSM state encoding.
package oscilo_pkg;

  localparam int MEM_ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LATCH  = 3'd2,
    SEND   = 3'd3,
    FINISH = 3'd4
  } dump_state_e;

endpackage

// File: rtl/mem_dump.sv
// Streams the whole sample memory, lowest address first, to a UART transmitter
// through a valid/ready byte handshake while activate is held high.
module mem_dump
  import oscilo_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clk_50mhz,
  input  logic              reset,
  input  logic              activate,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  dump_state_e       state_r;
  dump_state_e       state_next_s;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [ADDR_W-1:0] addr_next_s;
  logic [7:0]        tx_data_r;
  logic              tx_valid_r;
  logic              mem_re_r;
  logic              done_r;
  logic              handshake_s;
  logic              last_addr_s;

  assign handshake_s = (state_r == SEND) && tx_valid_r && tx_ready;
  assign last_addr_s = (mem_addr_r == {ADDR_W{1'b1}});

  // Next-state and next-address decode.
  always_comb begin
    state_next_s = state_r;
    addr_next_s  = mem_addr_r;
    case (state_r)
      IDLE: begin
        if (activate) begin
          state_next_s = FETCH;
          addr_next_s  = {ADDR_W{1'b0}};
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH: state_next_s = LATCH;
      LATCH: state_next_s = SEND;
      SEND: begin
        if (handshake_s) begin
          // A dropped activate wins over completion: the dump is abandoned, not finished.
          if (!activate) begin
            state_next_s = IDLE;
          end else if (last_addr_s) begin
            state_next_s = FINISH;
          end else begin
            state_next_s = FETCH;
            addr_next_s  = mem_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_next_s = SEND;
        end
      end
      FINISH: begin
        if (activate) begin
          state_next_s = FINISH;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, address counter and registered outputs, all decoded from the next state.
  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      mem_addr_r <= {ADDR_W{1'b0}};
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      mem_re_r   <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      mem_addr_r <= addr_next_s;
      mem_re_r   <= (state_next_s == FETCH);
      tx_valid_r <= (state_next_s == SEND);
      done_r     <= (state_next_s == FINISH);
      if (state_r == LATCH) begin
        tx_data_r <= mem_rdata;
      end else if (handshake_s) begin
        tx_data_r <= 8'h00;
      end else begin
        tx_data_r <= tx_data_r;
      end
    end
  end

  assign done     = done_r;
  assign mem_addr = mem_addr_r;
  assign mem_re   = mem_re_r;
  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;

endmodule

// File: doc/mem_dump.md
MEM_DUMP -- requirements
Module: mem_dump

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the sample-memory address width (dump length 2**ADDR_W bytes).
REQ-002 The block SHALL have port clk_50mhz, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port activate, input, 1, a level request to dump memory.
REQ-005 The block SHALL have port done, output, 1, a level that is high once the full dump has been handed to the transmitter.
REQ-006 The block SHALL have port mem_addr, output, ADDR_W, the sample-memory read address.
REQ-007 The block SHALL have port mem_re, output, 1, the read enable; read data is valid exactly 1 cycle after mem_re.
REQ-008 The block SHALL have port mem_rdata, input, 8, the sample-memory read data.
REQ-009 The block SHALL have port tx_data, output, 8, the byte offered to the UART transmitter.
REQ-010 The block SHALL have port tx_valid, output, 1, meaning tx_data is valid.
REQ-011 The block SHALL have port tx_ready, input, 1, meaning the transmitter accepts the byte; a transfer occurs on a cycle with tx_valid && tx_ready.

Function
REQ-012 The FSM SHALL have states IDLE, FETCH, LATCH, SEND and FINISH.
REQ-013 IDLE: done=0, tx_valid=0, mem_re=0; if activate=1, then mem_addr<=0 and the next state is FETCH.
REQ-014 FETCH: mem_re=1 for exactly this one cycle at the current mem_addr; the next state is LATCH.
REQ-015 LATCH: tx_data<=mem_rdata and tx_valid<=1; the next state is SEND.
REQ-016 SEND: tx_valid and tx_data SHALL hold stable until the handshake cycle; tx_ready arriving before tx_valid SHALL be ignored.
REQ-017 On the SEND handshake: tx_valid<=0; if mem_addr==2**ADDR_W-1, the next state is FINISH; otherwise mem_addr<=mem_addr+1 and the next state is FETCH.
REQ-018 mem_addr SHALL never wrap during a dump; exactly 2**ADDR_W bytes are sent in ascending address order, 0 first.
REQ-019 With tx_ready tied high, the throughput SHALL be one byte per 3 cycles; latency from activate sampled high to the first tx_valid SHALL be 3 cycles.
REQ-020 FINISH: done=1, and all other outputs are idle; the block remains in FINISH while activate=1 and returns to IDLE (done=0 on the next cycle) when activate=0.
REQ-021 activate falling mid-dump SHALL abort the dump: a byte already in SEND completes its handshake, then the next state is IDLE without entering FINISH; activate falling in FETCH or LATCH proceeds to SEND for that byte, then aborts.
REQ-022 activate re-asserted in IDLE after an abort SHALL restart the dump at address 0.
REQ-023 mem_re SHALL never be high outside FETCH, and tx_valid SHALL never be high outside SEND.

Reset
REQ-024 Reset asserted SHALL immediately force state=IDLE, done=0, tx_valid=0, tx_data=0, mem_addr=0 and mem_re=0, including mid-handshake.
REQ-025 After reset deasserts, the block SHALL wait for a fresh activate sampled high in IDLE.

Structure
REQ-026 The state enum and the shared MEM_ADDR_W=8 constant SHALL live in the shared package oscilo_pkg.
REQ-027 The block SHALL be a single module with no sub-modules; the address counter and output registers are inline.

Verification
REQ-028 Memory preloaded with mem[i]=i, tx_ready=1, activate held high -> bytes 0x00..0xFF received in order, the first tx_valid 3 cycles after activate, done high after the 256th handshake.
REQ-029 tx_ready toggled randomly with mem[i]=~i -> all 256 bytes received correctly, tx_data stable whenever tx_valid=1 && tx_ready=0.
REQ-030 activate dropped while SEND is stalled on byte 0x10 (tx_ready=0) -> byte 0x10 is accepted once tx_ready=1, no further mem_re, back in IDLE, done stays 0.
REQ-031 Reset pulsed while tx_valid=1 at address 0x80 -> all outputs 0 asynchronously; re-activate -> the dump restarts at 0x00.
REQ-032 Dump completes, activate held high for 50 cycles -> done=1 throughout with no tx_valid; activate=0 -> done=0 next cycle.
REQ-033 ADDR_W=4 -> exactly 16 bytes sent, with mem_addr never exceeding 0xF.
